// File: rtl/rom_lookup_seq.sv
// rtl/rom_lookup_seq.sv - tagged request sequencer for a fixed-latency registered lookup ROM
//
// Purpose:
//   Accepts {addr, tag} requests on a valid/ready stream, issues them to a
//   ROM with a fixed read latency, carries the tag alongside the lookup in a
//   shift pipe and rejoins tag and ROM word into a first-word-fall-through
//   result FIFO. Requests are only accepted when a FIFO slot is guaranteed
//   for them, so downstream backpressure never loses a ROM word.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_ready        request handshake
//   in_addr, in_tag          request address and opaque tag
//   rom_ena, rom_addra       ROM read enable and address (pass-through)
//   rom_douta                ROM read data, valid ROM_LAT cycles after rom_ena
//   out_valid/out_ready      result handshake (FWFT head)
//   out_data, out_tag        ROM word and the tag of its request
//   ovf_err                  sticky flag: FIFO write attempted while full

module rom_lookup_seq #(
    parameter int MXADRB     = 9,
    parameter int MXDATB     = 11,
    parameter int TAGB       = 8,
    parameter int ROM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MXADRB-1:0] in_addr,
    input  logic [TAGB-1:0]   in_tag,
    output logic              rom_ena,
    output logic [MXADRB-1:0] rom_addra,
    input  logic [MXDATB-1:0] rom_douta,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MXDATB-1:0] out_data,
    output logic [TAGB-1:0]   out_tag,
    output logic              ovf_err
);

    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW:0]   CRED_LIM  = (CNTW + 1)'(FIFO_DEPTH);

    logic [ROM_LAT-1:0] pipe_vld;
    logic [TAGB-1:0]    pipe_tag [ROM_LAT];

    logic [MXDATB-1:0]  mem_data [FIFO_DEPTH];
    logic [TAGB-1:0]    mem_tag  [FIFO_DEPTH];
    logic [PTRW-1:0]    wr_ptr;
    logic [PTRW-1:0]    rd_ptr;
    logic [CNTW-1:0]    occ;
    logic [CNTW-1:0]    inflight;
    logic [CNTW:0]      used;

    logic push;
    logic pop;
    logic full;
    logic push_ok;

    // Lookups still inside the ROM each hold a reserved FIFO slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + {{(CNTW-1){1'b0}}, pipe_vld[i]};
        end
    end

    // Credit uses registered counts only, so in_ready has no path from
    // in_valid or out_ready; a pop frees its credit on the next cycle.
    assign used      = {1'b0, occ} + {1'b0, inflight};
    assign in_ready  = used < CRED_LIM;
    assign rom_ena   = in_valid & in_ready;
    assign rom_addra = in_addr;

    assign out_valid = occ != '0;
    assign out_data  = mem_data[rd_ptr];
    assign out_tag   = mem_tag[rd_ptr];

    // The ROM output register holds stale data while ena is low, so the
    // pipe valid alone decides when rom_douta is captured.
    assign push    = pipe_vld[ROM_LAT-1];
    assign pop     = out_valid & out_ready;
    assign full    = occ == CNT_FULL;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            ovf_err  <= 1'b0;
        end else begin
            pipe_vld[0] <= rom_ena;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   occ <= occ + CNT_ONE;
                2'b01:   occ <= occ - CNT_ONE;
                default: occ <= occ;
            endcase
            if (push & ~push_ok) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // Data-path storage needs no reset: valids and pointers gate its use.
    always_ff @(posedge clk) begin
        pipe_tag[0] <= in_tag;
        for (int i = 1; i < ROM_LAT; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
        if (push_ok) begin
            mem_data[wr_ptr] <= rom_douta;
            mem_tag[wr_ptr]  <= pipe_tag[ROM_LAT-1];
        end
    end

endmodule
